// File: rtl/reg_share_arb.sv
// reg_share_arb: four requesters share one WIDTH-bit register through a
// round-robin arbiter. Each write takes a GRANT cycle followed by a COMMIT
// cycle. If the winner drops its request during GRANT, the write is aborted.
// Optional feature: define REG_SHARE_PRIO0_EN to give requester 0 absolute
// priority. Round-robin then applies among requesters 1-3 only while req[0]
// is low.
module reg_share_arb #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] wdata,
    output logic [3:0]         gnt,
    output logic [3:0]         done,
    output logic [WIDTH-1:0]   q,
    output logic [WIDTH-1:0]   qb,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, GRANT, COMMIT} state_e;

    state_e           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;   // last committed requester
    logic [1:0]       win_q, win_d;   // requester holding the current grant
    logic [3:0]       gnt_q, gnt_d;
    logic [3:0]       done_q, done_d;
    logic [WIDTH-1:0] q_q, q_d;

    logic             pick_vld;
    logic [1:0]       pick;
    logic [1:0]       idx;
    logic             found;

    // Round-robin pick: first set req bit searching ptr+1, ptr+2, ... mod 4
    always_comb begin
        pick_vld = |req;
        pick     = ptr_q + 2'd1;
        idx      = ptr_q;
        found    = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
`ifdef REG_SHARE_PRIO0_EN
        if (req[0]) pick = 2'd0;
`else
`endif
    end

    // Next-state and registered-output logic for the grant/commit sequence
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        gnt_d   = 4'b0000;
        done_d  = 4'b0000;
        q_d     = q_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = GRANT;
                    win_d   = pick;
                    gnt_d   = 4'b0001 << pick;
                end
            end
            GRANT: begin
                // Only the winner's own request decides commit vs abort
                if (req[win_q]) begin
                    state_d = COMMIT;
                    q_d     = wdata[win_q*WIDTH +: WIDTH];
                    ptr_d   = win_q;
                    done_d  = 4'b0001 << win_q;
                end else begin
                    state_d = IDLE;
                end
            end
            COMMIT: begin
                // ptr_q already holds this commit's winner, so back-to-back
                // arbitration rotates correctly
                if (pick_vld) begin
                    state_d = GRANT;
                    win_d   = pick;
                    gnt_d   = 4'b0001 << pick;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset leaves ptr at 3 so requester 0 is searched first
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd3;
            win_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            done_q  <= 4'b0000;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            q_q     <= q_d;
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign q    = q_q;
    assign qb   = ~q_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_reg_share_arb.sv
// Directed bench for reg_share_arb (WIDTH=8). Each task drives its scenario
// and checks outputs 1ns after the rising edge.
module tb_reg_share_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [7:0]  q;
    logic [7:0]  qb;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    reg_share_arb #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .req(req), .wdata(wdata),
        .gnt(gnt), .done(done), .q(q), .qb(qb), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        wdata = 32'hFFFF_FFFF;
        tick();
        tick();
        n_chk++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        n_chk++; if (done !== 4'b0000) begin n_fail++; $display("FAIL reset_done got=%b exp=0000", done); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_chk++; if (q !== 8'h00) begin n_fail++; $display("FAIL reset_q got=%h exp=00", q); end
        n_chk++; if (qb !== 8'hFF) begin n_fail++; $display("FAIL reset_qb got=%h exp=ff", qb); end
        rst = 1'b0;
        req = 4'b0000;
        tick();
        tick();
        n_chk++; if (busy !== 1'b0 || gnt !== 4'b0000) begin n_fail++; $display("FAIL idle_hold busy=%b gnt=%b exp 0/0000", busy, gnt); end
    endtask

    task automatic test_single_write();
        do_reset();
        wdata = 32'h00A5_0000;
        req = 4'b0100;
        tick();
        n_chk++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL single_gnt got=%b exp=0100", gnt); end
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got=%b exp=1", busy); end
        n_chk++; if (q !== 8'h00) begin n_fail++; $display("FAIL single_q_early got=%h exp=00", q); end
        tick();
        req = 4'b0000;
        n_chk++; if (q !== 8'hA5) begin n_fail++; $display("FAIL single_q got=%h exp=a5", q); end
        n_chk++; if (qb !== 8'h5A) begin n_fail++; $display("FAIL single_qb got=%h exp=5a", qb); end
        n_chk++; if (done !== 4'b0100) begin n_fail++; $display("FAIL single_done got=%b exp=0100", done); end
        n_chk++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL single_gnt_commit got=%b exp=0000", gnt); end
        tick();
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end got=%b exp=0", busy); end
        n_chk++; if (done !== 4'b0000) begin n_fail++; $display("FAIL single_done_end got=%b exp=0000", done); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_w;
        logic [7:0] exp_q;
        do_reset();
        wdata = {8'h44, 8'h33, 8'h22, 8'h11};
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
`ifdef REG_SHARE_PRIO0_EN
            exp_w = 2'd0;
`else
            exp_w = 2'(i % 4);
`endif
            exp_q = 8'(8'h11 * (exp_w + 1));
            tick();
            n_chk++; if (gnt !== (4'b0001 << exp_w)) begin n_fail++; $display("FAIL rr_gnt[%0d] got=%b exp_winner=%0d", i, gnt, exp_w); end
            n_chk++; if (done !== 4'b0000) begin n_fail++; $display("FAIL rr_done_in_grant[%0d] got=%b exp=0000", i, done); end
            tick();
            n_chk++; if (q !== exp_q) begin n_fail++; $display("FAIL rr_q[%0d] got=%h exp=%h", i, q, exp_q); end
            n_chk++; if (done !== (4'b0001 << exp_w)) begin n_fail++; $display("FAIL rr_done[%0d] got=%b exp_winner=%0d", i, done, exp_w); end
            n_chk++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rr_gnt_commit[%0d] got=%b exp=0000", i, gnt); end
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_abort();
        do_reset();
        wdata = {8'h44, 8'h33, 8'h22, 8'h11};
        req = 4'b0010;
        tick();
        n_chk++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL abort_gnt got=%b exp=0010", gnt); end
        req = 4'b0000;
        tick();
        n_chk++; if (q !== 8'h00) begin n_fail++; $display("FAIL abort_q got=%h exp=00", q); end
        n_chk++; if (done !== 4'b0000) begin n_fail++; $display("FAIL abort_done got=%b exp=0000", done); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", busy); end
        // ptr still 3, so 0110 must go to requester 1, not 2
        req = 4'b0110;
        tick();
        n_chk++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL abort_rearb got=%b exp=0010", gnt); end
        // other bits change mid-GRANT; the transaction for requester 1 must hold
        req = 4'b1011;
        wdata = {8'h44, 8'h33, 8'h5C, 8'h11};
        tick();
        n_chk++; if (q !== 8'h5C) begin n_fail++; $display("FAIL grant_stable_q got=%h exp=5c", q); end
        n_chk++; if (done !== 4'b0010) begin n_fail++; $display("FAIL grant_stable_done got=%b exp=0010", done); end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        wdata = 32'h0000_00FF;
        req = 4'b0001;
        tick();
        n_chk++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL rstmid_gnt got=%b exp=0001", gnt); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_chk++; if (q !== 8'h00) begin n_fail++; $display("FAIL rstmid_q got=%h exp=00", q); end
        n_chk++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rstmid_gnt0 got=%b exp=0000", gnt); end
        n_chk++; if (done !== 4'b0000) begin n_fail++; $display("FAIL rstmid_done got=%b exp=0000", done); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        tick();
        n_chk++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL rstmid_regrant got=%b exp=0001", gnt); end
        req = 4'b0000;
        tick();
        n_chk++; if (done !== 4'b0000 || q !== 8'h00) begin n_fail++; $display("FAIL rstmid_abort2 done=%b q=%h exp 0000/00", done, q); end
    endtask

    task automatic test_prio0();
        int ord [4];
`ifdef REG_SHARE_PRIO0_EN
        ord = '{0, 0, 0, 0};
`else
        ord = '{0, 1, 3, 0};
`endif
        do_reset();
        wdata = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        req = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_chk++; if (gnt !== (4'b0001 << ord[i])) begin n_fail++; $display("FAIL prio_gnt[%0d] got=%b exp_winner=%0d", i, gnt, ord[i]); end
            tick();
            n_chk++; if (done !== (4'b0001 << ord[i])) begin n_fail++; $display("FAIL prio_done[%0d] got=%b exp_winner=%0d", i, done, ord[i]); end
        end
        req = 4'b0000;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        wdata = '0;
        test_reset();
        test_single_write();
        test_round_robin();
        test_abort();
        test_reset_mid_grant();
        test_prio0();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
